// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFOs: Gray-code conversion and depth derivation.
// The converters work on right-aligned values of any width up to PtrMaxW bits.
package stream_fifo_pkg;

  localparam int unsigned PtrMaxW = 32;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero, so a narrower value decodes correctly in place.
  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] g);
    logic [PtrMaxW-1:0] b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/stream_gray_sync.sv
// Carries a binary pointer across clock domains: Gray-encoded and registered in the
// source clock, two-flop synchronised in the destination clock, decoded back to binary.
module stream_gray_sync
  import stream_fifo_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         rstn,
  input  logic         i_sclk,
  input  logic [W-1:0] i_bin,
  input  logic         i_dclk,
  output logic [W-1:0] o_bin
);

  logic [PtrMaxW-1:0] w_gray_full;
  logic [PtrMaxW-1:0] w_bin_full;
  logic [W-1:0]       r_gray;
  logic [W-1:0]       r_sync1;
  logic [W-1:0]       r_sync2;
  logic               w_unused_hi;

  assign w_gray_full = bin2gray(PtrMaxW'(i_bin));
  assign w_bin_full  = gray2bin(PtrMaxW'(r_sync2));
  assign w_unused_hi = ^{w_gray_full[PtrMaxW-1:W], w_bin_full[PtrMaxW-1:W]};

  always_ff @(posedge i_sclk or negedge rstn) begin
    if (!rstn) begin
      r_gray <= '0;
    end else begin
      r_gray <= w_gray_full[W-1:0];
    end
  end

  always_ff @(posedge i_dclk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= r_gray;
      r_sync2 <= r_sync1;
    end
  end

  assign o_bin = w_bin_full[W-1:0];

endmodule

// File: rtl/stream_async_fifo_pkt.sv
// Dual-clock stream FIFO with a last side-band bit, optional packet mode (reader only
// sees whole packets), pessimistic fill counts on both sides and a write-side almost-full.
module stream_async_fifo_pkt
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DSIZE        = 8,
  parameter int unsigned ASIZE        = 10,
  parameter int unsigned PKT_MODE     = 0,
  parameter int unsigned AFULL_THRESH = (32'd1 << ASIZE) - 4
) (
  input  logic             rstn,
  input  logic             iclk,
  input  logic             itvalid,
  output logic             itready,
  input  logic [DSIZE-1:0] itdata,
  input  logic             itlast,
  input  logic             oclk,
  output logic             otvalid,
  input  logic             otready,
  output logic [DSIZE-1:0] otdata,
  output logic             otlast,
  output logic [ASIZE:0]   wcount,
  output logic [ASIZE:0]   rcount,
  output logic             w_afull
);

  localparam int unsigned DEPTH    = fifo_depth(ASIZE);
  localparam int unsigned PtrW     = ASIZE + 1;
  localparam logic [ASIZE:0] DepthPtr = PtrW'(DEPTH);

  logic [DSIZE:0] r_mem [DEPTH];

  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_wcptr;
  logic [ASIZE:0] r_rptr;
  logic [ASIZE:0] w_wexp;
  logic [ASIZE:0] w_wsync;
  logic [ASIZE:0] w_rsync;
  logic           w_full;
  logic           w_wr;
  logic           w_empty;
  logic           w_rdready;
  logic           w_rd;
  logic           r_otvalid;
  logic [DSIZE:0] r_rdata;

  // ---------------- write side ----------------
  assign wcount  = r_wptr - w_rsync;
  assign w_full  = (wcount == DepthPtr);
  assign itready = rstn & ~w_full;
  assign w_wr    = itvalid & itready;
  assign w_afull = (32'(wcount) >= AFULL_THRESH);

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_wcptr <= '0;
    end else if (w_wr) begin
      r_wptr <= r_wptr + 1'b1;
      if (itlast) begin
        r_wcptr <= r_wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (w_wr) begin
      r_mem[r_wptr[ASIZE-1:0]] <= {itlast, itdata};
    end
  end

  // Packet mode hides uncommitted beats by exporting only the commit pointer.
  assign w_wexp = (PKT_MODE != 0) ? r_wcptr : r_wptr;

  stream_gray_sync #(
    .W (PtrW)
  ) u_w2r (
    .rstn   (rstn),
    .i_sclk (iclk),
    .i_bin  (w_wexp),
    .i_dclk (oclk),
    .o_bin  (w_wsync)
  );

  stream_gray_sync #(
    .W (PtrW)
  ) u_r2w (
    .rstn   (rstn),
    .i_sclk (oclk),
    .i_bin  (r_rptr),
    .i_dclk (iclk),
    .o_bin  (w_rsync)
  );

  // ---------------- read side ----------------
  assign rcount    = w_wsync - r_rptr;
  assign w_empty   = (w_wsync == r_rptr);
  assign w_rdready = ~r_otvalid | otready;
  assign w_rd      = ~w_empty & w_rdready;

  // r_rdata reloads only when the consumer can take data, so it also holds a stalled beat.
  always_ff @(posedge oclk or negedge rstn) begin
    if (!rstn) begin
      r_rptr    <= '0;
      r_otvalid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_otvalid <= ~w_empty | ~w_rdready;
      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
      end
    end
  end

  assign otvalid = r_otvalid;
  assign otlast  = r_rdata[DSIZE];
  assign otdata  = r_rdata[DSIZE-1:0];

endmodule

// File: tb/tb_stream_async_fifo_pkt.sv
// Bench for stream_async_fifo_pkt: a stream-mode and a packet-mode instance (DSIZE=8,
// ASIZE=4) checked against an in-order beat scoreboard with whole-packet release.
`timescale 1ns/1ps
module tb_stream_async_fifo_pkt;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic iclk = 1'b0;
  logic oclk = 1'b0;
  logic rstn = 1'b0;
  int unsigned ihalf = 5;
  int unsigned ohalf = 5;

  always begin #(ihalf); iclk = ~iclk; end
  always begin #(ohalf); oclk = ~oclk; end

  logic          itvalid [2];
  logic          itready [2];
  logic [DW-1:0] itdata  [2];
  logic          itlast  [2];
  logic          otvalid [2];
  logic          otready [2];
  logic [DW-1:0] otdata  [2];
  logic          otlast  [2];
  logic [AW:0]   wcount  [2];
  logic [AW:0]   rcount  [2];
  logic          w_afull [2];

  stream_async_fifo_pkt #(
    .DSIZE(DW), .ASIZE(AW), .PKT_MODE(0), .AFULL_THRESH(DEPTH - 4)
  ) u_dut_s (
    .rstn(rstn), .iclk(iclk), .itvalid(itvalid[0]), .itready(itready[0]),
    .itdata(itdata[0]), .itlast(itlast[0]), .oclk(oclk), .otvalid(otvalid[0]),
    .otready(otready[0]), .otdata(otdata[0]), .otlast(otlast[0]),
    .wcount(wcount[0]), .rcount(rcount[0]), .w_afull(w_afull[0])
  );

  stream_async_fifo_pkt #(
    .DSIZE(DW), .ASIZE(AW), .PKT_MODE(1), .AFULL_THRESH(DEPTH - 4)
  ) u_dut_p (
    .rstn(rstn), .iclk(iclk), .itvalid(itvalid[1]), .itready(itready[1]),
    .itdata(itdata[1]), .itlast(itlast[1]), .oclk(oclk), .otvalid(otvalid[1]),
    .otready(otready[1]), .otdata(otdata[1]), .otlast(otlast[1]),
    .wcount(wcount[1]), .rcount(rcount[1]), .w_afull(w_afull[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats leave in acceptance order; packet mode releases a packet
  // to the reader only once its last beat has been accepted.
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] pend_q[$];
  int acc_cnt [2];
  int rx_cnt  [2];
  bit wr_done [2];
  logic       hold_prev [2];
  logic [8:0] word_prev [2];

  function automatic void accept(input int d, input logic [8:0] w);
    acc_cnt[d]++;
    if (d == 0) begin
      exp_q0.push_back(w);
    end else begin
      pend_q.push_back(w);
      if (w[8]) begin
        while (pend_q.size() > 0) exp_q1.push_back(pend_q.pop_front());
      end
    end
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [8:0] pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Read-side monitor: ordering, stability under backpressure, rcount bound.
  always @(negedge oclk) begin
    logic [8:0] got;
    logic [8:0] expw;
    for (int d = 0; d < 2; d++) begin
      if (rstn) begin
        got = {otlast[d], otdata[d]};
        if (hold_prev[d] === 1'b1) begin
          n_tests++;
          if (got !== word_prev[d]) begin
            n_fail++;
            $display("FAIL hold_stable dut%0d: got %h, required %h", d, got, word_prev[d]);
          end
        end
        if (otvalid[d] === 1'b1 && otready[d] === 1'b1) begin
          n_tests++;
          rx_cnt[d]++;
          if (qsize(d) == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: got %h, required none", d, got);
          end else begin
            expw = pop_exp(d);
            if (got !== expw) begin
              n_fail++;
              $display("FAIL beat_order dut%0d: got %h, required %h", d, got, expw);
            end
          end
        end
        n_tests++;
        if (rcount[d] > 5'd16) begin
          n_fail++;
          $display("FAIL rcount_range dut%0d: got %0d, required <=16", d, rcount[d]);
        end
        hold_prev[d] = otvalid[d] & ~otready[d];
        word_prev[d] = got;
      end else begin
        hold_prev[d] = 1'b0;
      end
    end
  end

  // Write-side monitor: wcount bound and almost-full threshold rule.
  always @(negedge iclk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstn) begin
        n_tests++;
        if (wcount[d] > 5'd16) begin
          n_fail++;
          $display("FAIL wcount_range dut%0d: got %0d, required <=16", d, wcount[d]);
        end
        n_tests++;
        if (w_afull[d] !== (wcount[d] >= 5'd12)) begin
          n_fail++;
          $display("FAIL afull_rule dut%0d: got %b with wcount %0d", d, w_afull[d], wcount[d]);
        end
      end
    end
  end

  // Presents one beat from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic send(input int d, input logic [7:0] data, input logic last);
    bit acc;
    int t;
    itvalid[d] = 1'b1;
    itdata[d]  = data;
    itlast[d]  = last;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 4000) begin
      @(negedge iclk);
      acc = itready[d];
      if (acc) accept(d, {last, data});
      @(posedge iclk); #1;
      t++;
    end
    itvalid[d] = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout dut%0d: beat %h not accepted in %0d cycles", d, data, t);
    end
  endtask

  task automatic writer(input int d, input int n, input int gap_pct);
    int plen;
    logic last;
    plen = 0;
    @(posedge iclk); #1;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin @(posedge iclk); #1; end
      plen++;
      if (d == 1) last = (i == n - 1) || (plen >= 8) || ($urandom_range(0, 3) == 0);
      else        last = 1'($urandom);
      if (last) plen = 0;
      send(d, 8'($urandom), last);
    end
    wr_done[d] = 1'b1;
  endtask

  task automatic reader(input int d, input int pct, input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge oclk); #1;
      otready[d] = ($urandom_range(0, 99) < pct);
      if (wr_done[d] && qsize(d) == 0) break;
    end
    otready[d] = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (itready[d] !== 1'b0) begin n_fail++; $display("FAIL rst_itready dut%0d: got %b, required 0", d, itready[d]); end
      n_tests++; if (otvalid[d] !== 1'b0) begin n_fail++; $display("FAIL rst_otvalid dut%0d: got %b, required 0", d, otvalid[d]); end
      n_tests++; if ({otlast[d], otdata[d]} !== 9'h000) begin n_fail++; $display("FAIL rst_otdata dut%0d: got %h, required 000", d, {otlast[d], otdata[d]}); end
      n_tests++; if (wcount[d] !== 5'd0 || rcount[d] !== 5'd0) begin n_fail++; $display("FAIL rst_counts dut%0d: got %0d/%0d, required 0/0", d, wcount[d], rcount[d]); end
      n_tests++; if (w_afull[d] !== 1'b0) begin n_fail++; $display("FAIL rst_afull dut%0d: got %b, required 0", d, w_afull[d]); end
    end
    #21 rstn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (itready[d] !== 1'b1) begin n_fail++; $display("FAIL rst_release_itready dut%0d: got %b, required 1", d, itready[d]); end
    end
  endtask

  // Stalled reader: 16 RAM entries plus the beat held in the output register.
  task automatic test_fill();
    otready[0] = 1'b0;
    @(posedge iclk); #1;
    for (int i = 0; i <= DEPTH; i++) send(0, 8'(i), 1'b0);
    n_tests++; if (itready[0] !== 1'b0) begin n_fail++; $display("FAIL fill_itready: got %b, required 0", itready[0]); end
    n_tests++; if (wcount[0] !== 5'd16) begin n_fail++; $display("FAIL fill_wcount: got %0d, required 16", wcount[0]); end
    n_tests++; if (w_afull[0] !== 1'b1) begin n_fail++; $display("FAIL fill_afull: got %b, required 1", w_afull[0]); end
    repeat (8) @(posedge iclk); #1;
    n_tests++; if (itready[0] !== 1'b0) begin n_fail++; $display("FAIL fill_stays_full: got %b, required 0", itready[0]); end
    n_tests++; if (rcount[0] !== 5'd16) begin n_fail++; $display("FAIL fill_rcount: got %0d, required 16", rcount[0]); end
    n_tests++; if (otvalid[0] !== 1'b1 || otdata[0] !== 8'h00) begin n_fail++; $display("FAIL fill_head: got v=%b d=%h, required v=1 d=00", otvalid[0], otdata[0]); end
    otready[0] = 1'b1;
    for (int c = 0; c < 200 && qsize(0) != 0; c++) @(posedge oclk);
    repeat (8) @(posedge iclk); #1;
    n_tests++; if (qsize(0) != 0) begin n_fail++; $display("FAIL fill_drain: got %0d left, required 0", qsize(0)); end
    n_tests++; if (wcount[0] !== 5'd0 || rcount[0] !== 5'd0 || otvalid[0] !== 1'b0) begin
      n_fail++; $display("FAIL fill_empty_after: got w=%0d r=%0d v=%b, required 0/0/0", wcount[0], rcount[0], otvalid[0]);
    end
  endtask

  task automatic test_packet();
    logic       exp_v;
    logic [8:0] exp_w [3];
    exp_w[0] = 9'h0A1;
    exp_w[1] = 9'h0A2;
    exp_w[2] = 9'h1A3;
    otready[1] = 1'b1;
    @(posedge iclk); #1;
    send(1, 8'hA1, 1'b0);
    send(1, 8'hA2, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge oclk);
      n_tests++; if (otvalid[1] !== 1'b0) begin n_fail++; $display("FAIL pkt_partial_hidden cycle %0d: got %b, required 0", c, otvalid[1]); end
      @(posedge iclk); #1;
    end
    send(1, 8'hA3, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      @(negedge oclk);
      exp_v = (k >= 4 && k <= 6);
      n_tests++;
      if (otvalid[1] !== exp_v) begin
        n_fail++; $display("FAIL pkt_latency edge %0d: got %b, required %b", k, otvalid[1], exp_v);
      end else if (exp_v && {otlast[1], otdata[1]} !== exp_w[k-4]) begin
        n_fail++; $display("FAIL pkt_beat edge %0d: got %h, required %h", k, {otlast[1], otdata[1]}, exp_w[k-4]);
      end
      @(posedge oclk); #1;
    end
  endtask

  task automatic test_backpressure();
    wr_done[0] = 1'b0;
    fork
      writer(0, 300, 30);
      reader(0, 50, 5000);
    join
    n_tests++; if (qsize(0) != 0) begin n_fail++; $display("FAIL bp_lossless: got %0d left, required 0", qsize(0)); end
  endtask

  task automatic test_back_to_back();
    int nw;
    int nr;
    otready[0] = 1'b0;
    @(posedge iclk); #1;
    for (int i = 0; i <= DEPTH; i++) send(0, 8'(8'h40 + i), 1'b0);
    otready[0] = 1'b1;
    wr_done[0] = 1'b0;
    nw = 0;
    nr = 0;
    fork
      writer(0, 120, 0);
      begin
        repeat (40) @(negedge iclk);
        repeat (32) begin
          @(negedge iclk);
          if (itvalid[0] && itready[0]) nw++;
          if (otvalid[0] && otready[0]) nr++;
        end
      end
    join
    n_tests++; if (nw != 32) begin n_fail++; $display("FAIL b2b_write_rate: got %0d, required 32", nw); end
    n_tests++; if (nr != 32) begin n_fail++; $display("FAIL b2b_read_rate: got %0d, required 32", nr); end
    for (int c = 0; c < 200 && qsize(0) != 0; c++) @(posedge oclk);
    n_tests++; if (qsize(0) != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left, required 0", qsize(0)); end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    otready[0] = 1'b1;
    otready[1] = 1'b1;
    @(posedge iclk); #1;
    send(1, 8'h10, 1'b0);
    itvalid[1] = 1'b1; itdata[1] = 8'h11; itlast[1] = 1'b0;
    #2 rstn = 1'b0;
    exp_q0.delete(); exp_q1.delete(); pend_q.delete();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (itready[d] !== 1'b0 || otvalid[d] !== 1'b0 || {otlast[d], otdata[d]} !== 9'h000 ||
          wcount[d] !== 5'd0 || rcount[d] !== 5'd0 || w_afull[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_outputs dut%0d: got rdy=%b v=%b w=%h wc=%0d rc=%0d af=%b, required all 0",
                 d, itready[d], otvalid[d], {otlast[d], otdata[d]}, wcount[d], rcount[d], w_afull[d]);
      end
    end
    itvalid[1] = 1'b0;
    repeat (3) @(posedge iclk);
    #3 rstn = 1'b1;
    @(posedge iclk); #1;
    base = rx_cnt[1];
    send(1, 8'h55, 1'b1);
    repeat (30) @(posedge oclk);
    #1;
    n_tests++; if (rx_cnt[1] - base != 1) begin n_fail++; $display("FAIL midrst_alone: got %0d beats, required 1", rx_cnt[1] - base); end
    n_tests++; if (qsize(1) != 0) begin n_fail++; $display("FAIL midrst_drain: got %0d left, required 0", qsize(1)); end
  endtask

  task automatic test_ratio(input int unsigned ih, input int unsigned oh, input int rpct);
    ihalf = ih;
    ohalf = oh;
    wr_done[0] = 1'b0;
    wr_done[1] = 1'b0;
    fork
      writer(0, 5000, (ih < oh) ? 10 : 0);
      writer(1, 5000, (ih < oh) ? 10 : 0);
      reader(0, rpct, 60000);
      reader(1, rpct, 60000);
    join
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (qsize(d) != 0) begin n_fail++; $display("FAIL ratio_lossless dut%0d: got %0d left, required 0", d, qsize(d)); end
    end
    n_tests++; if (pend_q.size() != 0) begin n_fail++; $display("FAIL ratio_pending: got %0d, required 0", pend_q.size()); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      itvalid[d] = 1'b0; itdata[d] = '0; itlast[d] = 1'b0; otready[d] = 1'b0;
      acc_cnt[d] = 0; rx_cnt[d] = 0; wr_done[d] = 1'b0; hold_prev[d] = 1'b0; word_prev[d] = '0;
    end
    test_reset();
    test_fill();
    test_packet();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_ratio(5, 15, 100);
    test_ratio(15, 5, 60);
    n_tests++;
    if (acc_cnt[0] / 32 < 300) begin
      n_fail++; $display("FAIL pointer_wraps: got %0d, required >=300", acc_cnt[0] / 32);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
